// File: rtl/hilo_muldiv_controller.sv
// hilo_muldiv_controller
//   Multi-cycle multiply/divide unit that owns the HI/LO register pair.
//   MULT/MULTU use radix-2 shift-add and DIV/DIVU use restoring division.
//   Both work on operand magnitudes and apply signs in a final fix-up cycle.
//   From accept to the HI/LO write takes 33 enabled edges. MTHI/MTLO write
//   HI or LO directly at the accept edge.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous, active-low reset
//   clk_enable : when 0, all state holds (op counter frozen)
//   start      : request to launch op
//   op         : 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   srca, srcb : operands (srca is also the MTHI/MTLO data)
//   rd_req     : datapath is executing MFHI/MFLO
//   busy       : mul/div in progress
//   stall      : busy & (rd_req | start)
//   done       : one-cycle pulse after HI/LO are written
//   hi, lo     : HI/LO registers
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | waiting for start; MTHI/MTLO complete here
// MUL    | 32 shift-add steps on magnitudes
// DIV    | 32 restoring-division steps on magnitudes
// FIX    | apply signs / divide-by-zero result, write HI/LO, pulse done
module hilo_muldiv_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  logic        rd_req,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  // MUL: {partial product high, multiplier shifting out}
  // DIV: {remainder, dividend shifting out / quotient shifting in}
  logic [63:0] acc_q, acc_d;
  logic [31:0] opb_q, opb_d;       // multiplicand or divisor magnitude
  logic        is_div_q, is_div_d;
  logic        neg_lo_q, neg_lo_d; // negate product / quotient
  logic        neg_hi_q, neg_hi_d; // negate remainder
  logic        divz_q, divz_d;
  logic        done_q, done_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift;
  logic [31:0] div_diff;
  logic        div_ge;
  logic [63:0] div_next;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  always_comb begin
    // op[0]==0 selects the signed flavours (MULT, DIV)
    a_neg = ~op[0] & srca[31];
    b_neg = ~op[0] & srcb[31];
    a_mag = a_neg ? (32'd0 - srca) : srca;
    b_mag = b_neg ? (32'd0 - srcb) : srcb;

    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};

    div_shift = {acc_q[63:32], acc_q[31]};
    div_ge    = (div_shift >= {1'b0, opb_q});
    // Only used when div_ge, so the difference always fits in 32 bits
    div_diff  = div_shift[31:0] - opb_q;
    div_next  = {(div_ge ? div_diff : div_shift[31:0]), acc_q[30:0], div_ge};

    prod_fix = neg_lo_q ? (64'd0 - acc_q) : acc_q;
    quo_fix  = neg_lo_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    rem_fix  = neg_hi_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    divz_d   = divz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    if (clk_enable) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                state_d  = S_MUL;
                cnt_d    = 5'd0;
                acc_d    = {32'd0, b_mag};
                opb_d    = a_mag;
                is_div_d = 1'b0;
                neg_lo_d = a_neg ^ b_neg;
                neg_hi_d = 1'b0;
                divz_d   = 1'b0;
              end
              OP_DIV, OP_DIVU: begin
                state_d  = S_DIV;
                cnt_d    = 5'd0;
                acc_d    = {32'd0, a_mag};
                opb_d    = b_mag;
                is_div_d = 1'b1;
                neg_lo_d = a_neg ^ b_neg;
                neg_hi_d = a_neg;
                divz_d   = (srcb == 32'd0);
              end
              OP_MTHI: hi_d = srca;
              OP_MTLO: lo_d = srca;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          acc_d = mul_next;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = S_FIX;
        end
        S_DIV: begin
          acc_d = div_next;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = S_FIX;
        end
        S_FIX: begin
          if (is_div_q) begin
            // Divide-by-zero: the magnitude loop leaves |srca| as the
            // remainder, so the signed remainder already equals srca
            hi_d = rem_fix;
            lo_d = divz_q ? 32'hFFFF_FFFF : quo_fix;
          end else begin
            hi_d = prod_fix[63:32];
            lo_d = prod_fix[31:0];
          end
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      opb_q    <= 32'd0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      divz_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      divz_q   <= divz_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign stall = busy & (rd_req | start);
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: doc/hilo_muldiv_controller.md
HILO_MULDIV_CONTROLLER -- requirements
Module: hilo_muldiv_controller

Interface
REQ-001 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-low (0 = reset asserted).
REQ-003 SHALL have port clk_enable, input, 1: when 0, all state holds and the op counter is frozen.
REQ-004 SHALL have port start, input, 1: request to launch op.
REQ-005 SHALL have port op, input, 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 11x is ignored.
REQ-006 SHALL have port srca, input, 32: multiplicand/dividend/MTxx data.
REQ-007 SHALL have port srcb, input, 32: multiplier/divisor.
REQ-008 SHALL have port rd_req, input, 1: the datapath is executing MFHI/MFLO.
REQ-009 SHALL have port busy, output, 1: a mul/div op is in progress.
REQ-010 SHALL have port stall, output, 1: datapath must hold PC and instruction.
REQ-011 SHALL have port done, output, 1: one-cycle pulse when results land.
REQ-012 SHALL have port hi, output, 32: HI register.
REQ-013 SHALL have port lo, output, 32: LO register.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, DIV, FIX.
REQ-015 Accept SHALL occur on an edge with state IDLE, start=1, clk_enable=1 and valid op; srca/srcb are captured at that edge.
REQ-016 MULT/MULTU accept SHALL go to MUL; DIV/DIVU accept SHALL go to DIV; the counter loads 0.
REQ-017 MUL SHALL do radix-2 shift-add on operand magnitudes, one bit per enabled edge, 32 edges, then go to FIX.
REQ-018 DIV SHALL do restoring division on magnitudes, one quotient bit per enabled edge, 32 edges, then go to FIX.
REQ-019 FIX SHALL apply signs and write hi/lo, assert done for the following cycle, and return to IDLE.
- Signed MULT: negate the 64-bit product if the operand signs differ.
- Signed DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
REQ-020 Latency SHALL be 33 enabled edges from accept to hi/lo update; busy=1 throughout that interval.
REQ-021 Divisor zero (DIV or DIVU) SHALL give lo=32'hFFFFFFFF and hi=srca, with unchanged latency.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0.
REQ-023 MTHI/MTLO accepted in IDLE SHALL write hi/lo at the accept edge; busy stays 0 and done is not pulsed.
REQ-024 stall SHALL be combinational: stall = busy & (rd_req | start).
- start while busy is not accepted; it is held off by stall until IDLE.
REQ-025 hi/lo SHALL hold their old values during MUL/DIV.
- MFHI/MFLO never observe partial results.
REQ-026 clk_enable=0 mid-operation SHALL freeze the state, counter and partial results; latency extends by exactly the frozen cycles.
REQ-027 Invalid op with start=1 in IDLE SHALL cause no state change.

Reset
REQ-028 reset=0 SHALL immediately force state IDLE, counter 0, busy=0, done=0, hi=0 and lo=0, regardless of clk or clk_enable.
REQ-029 reset asserted mid-operation SHALL abort the op with no result write.
REQ-030 After release, the first accept SHALL be possible at the first rising edge with reset=1.

Verification
REQ-031 Bench SHALL cover MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy for exactly 33 edges, then hi=0xFFFFFFFE, lo=0x00000001, done pulse of 1 cycle.
REQ-032 Bench SHALL cover MULT 0xFFFFFFFD (-3) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-033 Bench SHALL cover the following divides:
- DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 7 / 0 -> lo=0xFFFFFFFF, hi=7.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 Bench SHALL cover rd_req=1 and a second start during busy -> stall=1 every cycle until FIX completes.
- Second op accepted on the first IDLE edge.
- Its result correct.
REQ-035 Bench SHALL cover reset=0 at edge 10 of a DIV -> busy=0, hi=lo=0 without a clock edge, and no done pulse.
- Also: clk_enable=0 for 5 cycles mid-MUL -> result after 38 edges, value correct.
REQ-036 Bench SHALL cover MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive edges -> hi/lo updated at each accept edge, busy=0, stall=0.
